// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the request legality check.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_CAP,
        ST_WR,
        RMW_RD,
        RMW_MERGE,
        RMW_WR,
        RESP
    } lsu_state_e;

    // Request is rejected if direction is ambiguous, the width code is not
    // legal for that direction, the access is misaligned or out of range.
    function automatic logic lsu_req_error(
        input logic        load,
        input logic        store,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input logic [31:0] mem_bytes
    );
        logic bad;
        bad = (load == store);
        if (load) begin
            case (funct3)
                LB, LH, LW, LBU, LHU: bad = bad;
                default:              bad = 1'b1;
            endcase
        end
        if (store) begin
            case (funct3)
                SB, SH, SW: bad = bad;
                default:    bad = 1'b1;
            endcase
        end
        if (funct3[1:0] == 2'b01 && addr[0])
            bad = 1'b1;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            bad = 1'b1;
        if (addr >= mem_bytes)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: formats load data from a memory word
// and merges sub-word store data into a word for read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rdata,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_lane, 3'b000} +: 8];
        w_half = i_rdata[{i_lane[1], 4'b0000} +: 16];

        case (i_funct3)
            LB:      o_load_data = {{24{w_byte[7]}}, w_byte};
            LBU:     o_load_data = {24'h000000, w_byte};
            LH:      o_load_data = {{16{w_half[15]}}, w_half};
            LHU:     o_load_data = {16'h0000, w_half};
            default: o_load_data = i_rdata;
        endcase

        o_merged = i_rdata;
        if (i_funct3 == SB)
            o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
        else if (i_funct3 == SH)
            o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata;
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a registered-output word memory;
// sub-word stores are done as read-modify-write of the containing word.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    lsu_state_e  r_state;
    logic        r_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_write_data;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;

    logic        w_err;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_err = lsu_req_error(req_load, req_store, req_funct3, req_addr, 32'(MEM_BYTES));

    lsu_align u_align (
        .i_funct3    (r_funct3),
        .i_lane      (r_lane),
        .i_rdata     (mem_read_data),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_ready          <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_resp_rdata     <= '0;
            r_resp_err       <= 1'b0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_funct3         <= '0;
            r_lane           <= '0;
            r_wdata          <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && r_ready) begin
                        r_ready  <= 1'b0;
                        r_funct3 <= req_funct3;
                        r_lane   <= req_addr[1:0];
                        r_wdata  <= req_wdata[15:0];
                        if (w_err) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_mem_address <= {req_addr[31:2], 2'b00};
                            if (req_load) begin
                                r_state    <= LD_REQ;
                                r_mem_read <= 1'b1;
                            end else if (req_funct3 == SW) begin
                                r_state          <= ST_WR;
                                r_mem_write      <= 1'b1;
                                r_mem_write_data <= req_wdata;
                            end else begin
                                r_state    <= RMW_RD;
                                r_mem_read <= 1'b1;
                            end
                        end
                    end
                end
                LD_REQ: begin
                    r_mem_read <= 1'b0;
                    r_state    <= LD_CAP;
                end
                LD_CAP: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= w_load_data;
                    r_state      <= RESP;
                end
                ST_WR: begin
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_state      <= RESP;
                end
                RMW_RD: begin
                    r_mem_read <= 1'b0;
                    r_state    <= RMW_MERGE;
                end
                // Memory word is visible here; the write is only committed from RMW_WR.
                RMW_MERGE: begin
                    r_mem_write_data <= w_merged;
                    r_mem_write      <= 1'b1;
                    r_state          <= RMW_WR;
                end
                RMW_WR: begin
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready      = r_ready;
    assign resp_valid     = r_resp_valid;
    assign resp_rdata     = r_resp_rdata;
    assign resp_err       = r_resp_err;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory model, per-cycle
// response scoreboard and directed vectors with hand-computed results.
module tb_load_store_unit;

    localparam logic [2:0] F_LB = 3'b000, F_LH = 3'b001, F_LW = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100, F_LHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_read(mem_read),
        .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    logic do_init;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h40) return 32'h8899AABB;
        return i * 32'h9E3779B1;
    endfunction

    // Attached word memory with registered read output.
    logic [31:0] mem [256];
    logic [31:0] mem_rd_q;
    assign mem_read_data = mem_rd_q;
    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else begin
            if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
            if (mem_read)  mem_rd_q <= mem[mem_address[9:2]];
        end
    end

    always @(negedge clk) begin
        if (mem_read)  rd_cnt <= rd_cnt + 1;
        if (mem_write) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, expv);
        end
    endtask

    // Reference model: byte-addressed memory and the access rules.
    logic [7:0] ref_mem [1024];

    function automatic void model(input logic ld, input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd, input bit commit,
                                  output logic err, output logic [31:0] rd,
                                  output int lat, output int nrd, output int nwr);
        int  n;
        bit  legal;
        n = 1 << f3[1:0];
        if (ld && !st)      legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (st && !ld) legal = f3 inside {3'b000, 3'b001, 3'b010};
        else                legal = 1'b0;
        err = !legal || (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00) || (a >= 32'd1024);
        rd  = '0;
        if (err) begin
            lat = 1; nrd = 0; nwr = 0;
        end else if (ld) begin
            for (int i = 0; i < n; i++) rd |= 32'(ref_mem[int'(a) + i]) << (8 * i);
            if (!f3[2] && n < 4 && rd[8 * n - 1]) rd |= 32'hFFFFFFFF << (8 * n);
            lat = 3; nrd = 1; nwr = 0;
        end else begin
            if (commit)
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8 * i +: 8];
            lat = (n == 4) ? 2 : 4; nrd = (n == 4) ? 0 : 1; nwr = 1;
        end
    endfunction

    typedef struct { int due; logic [31:0] rdata; logic err; } exp_t;
    exp_t exp_q [$];
    logic [31:0] last_rdata = '0;
    logic        last_err   = 1'b0;

    // Per-cycle scoreboard: response timing/contents, held values, port rules.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            last_rdata = '0;
            last_err   = 1'b0;
        end else begin
            logic exp_v;
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("resp_valid", 32'(resp_valid), 32'(exp_v));
            if (exp_v) begin
                check("resp_rdata", resp_rdata, exp_q[0].rdata);
                check("resp_err", 32'(resp_err), 32'(exp_q[0].err));
                last_rdata = exp_q[0].rdata;
                last_err   = exp_q[0].err;
                void'(exp_q.pop_front());
            end else begin
                check("rdata_hold", resp_rdata, last_rdata);
                check("err_hold", 32'(resp_err), 32'(last_err));
            end
            if (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
            check("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
            check("addr_align", 32'(mem_address[1:0]), 32'd0);
        end
    end

    task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit wait_resp, input bit hold, input bit commit,
                          output int acc, output logic [31:0] got_rdata, output logic got_err);
        logic        e_err;
        logic [31:0] e_rd;
        int          lat, nrd, nwr, rd0, wr0;
        req_valid = 1'b1; req_load = ld; req_store = st;
        req_funct3 = f3; req_addr = a; req_wdata = wd;
        acc = -1; got_rdata = 'x; got_err = 1'bx;
        for (int k = 0; k < 20; k++) begin
            if (req_ready) begin
                acc = cyc;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        if (acc < 0) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout at cycle %0d: got no acceptance, expected within 20 cycles", cyc);
            req_valid = 1'b0;
            return;
        end
        rd0 = rd_cnt; wr0 = wr_cnt;
        if (!hold) begin
            req_valid = 1'b0; req_load = 1'($urandom); req_store = 1'($urandom);
            req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        end
        model(ld, st, f3, a, wd, commit, e_err, e_rd, lat, nrd, nwr);
        if (commit) exp_q.push_back('{due: acc + lat, rdata: e_rd, err: e_err});
        if (wait_resp) begin
            while (cyc < acc + lat) begin @(posedge clk); #1; end
            got_rdata = resp_rdata;
            got_err   = resp_err;
            @(posedge clk); #1;
            check("mem_read_pulses", 32'(rd_cnt - rd0), 32'(nrd));
            check("mem_write_pulses", 32'(wr_cnt - wr0), 32'(nwr));
        end
    endtask

    int          acc, acc2;
    logic [31:0] r;
    logic        e;
    logic [31:0] w;

    initial begin
        rst = 1'b1; do_init = 1'b1;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            w = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = w[8 * b +: 8];
        end
        repeat (3) @(posedge clk);
        #1;
        do_init = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Loads from word 0x8899AABB
        do_req(1, 0, F_LB,  32'h102, 0, 1, 0, 1, acc, r, e); check("lb_0x102", r, 32'hFFFFFF99);
        do_req(1, 0, F_LBU, 32'h102, 0, 1, 0, 1, acc, r, e); check("lbu_0x102", r, 32'h00000099);
        do_req(1, 0, F_LH,  32'h102, 0, 1, 0, 1, acc, r, e); check("lh_0x102", r, 32'hFFFF8899);
        do_req(1, 0, F_LHU, 32'h102, 0, 1, 0, 1, acc, r, e); check("lhu_0x102", r, 32'h00008899);
        do_req(1, 0, F_LW,  32'h100, 0, 1, 0, 1, acc, r, e); check("lw_0x100", r, 32'h8899AABB);
        do_req(1, 0, F_LBU, 32'h100, 0, 1, 0, 1, acc, r, e); check("lbu_0x100", r, 32'h000000BB);

        // Byte store read-modify-write
        do_req(0, 1, F_LB, 32'h101, 32'h12345677, 1, 0, 1, acc, r, e);
        check("sb_err", 32'(e), 32'd0);
        check("sb_mem_word", mem[8'h40], 32'h889977BB);
        do_req(1, 0, F_LW, 32'h100, 0, 1, 0, 1, acc, r, e); check("lw_after_sb", r, 32'h889977BB);

        // Illegal requests
        do_req(1, 0, F_LW,   32'h102, 0, 1, 0, 1, acc, r, e); check("err_lw_mis", 32'(e), 32'd1);
        do_req(0, 1, F_LH,   32'h103, 0, 1, 0, 1, acc, r, e); check("err_sh_mis", 32'(e), 32'd1);
        do_req(1, 0, F_LW,   32'h400, 0, 1, 0, 1, acc, r, e); check("err_range", 32'(e), 32'd1);
        check("err_rdata", r, 32'd0);
        do_req(1, 1, F_LW,   32'h100, 0, 1, 0, 1, acc, r, e); check("err_both", 32'(e), 32'd1);
        do_req(0, 0, F_LW,   32'h100, 0, 1, 0, 1, acc, r, e); check("err_neither", 32'(e), 32'd1);
        do_req(1, 0, 3'b011, 32'h100, 0, 1, 0, 1, acc, r, e); check("err_ld_f3", 32'(e), 32'd1);
        do_req(0, 1, 3'b100, 32'h100, 0, 1, 0, 1, acc, r, e); check("err_st_f3", 32'(e), 32'd1);
        do_req(1, 0, F_LB,   32'h400, 0, 1, 0, 1, acc, r, e); check("err_lb_range", 32'(e), 32'd1);

        // Back-to-back store then load with req_valid held high
        do_req(0, 1, F_LW, 32'h200, 32'hCAFEF00D, 0, 1, 1, acc, r, e);
        do_req(1, 0, F_LW, 32'h200, 0, 1, 0, 1, acc2, r, e);
        check("b2b_accept_cycle", 32'(acc2 - acc), 32'd3);
        check("b2b_lw", r, 32'hCAFEF00D);

        do_req(0, 1, F_LH, 32'h202, 32'h1234ABCD, 1, 0, 1, acc, r, e);
        do_req(1, 0, F_LW, 32'h200, 0, 1, 0, 1, acc, r, e); check("lw_after_sh", r, 32'hABCDF00D);
        do_req(1, 0, F_LB, 32'h203, 0, 1, 0, 1, acc, r, e); check("lb_0x203", r, 32'hFFFFFFAB);

        // Top-of-range accesses
        do_req(1, 0, F_LHU, 32'h3FE, 0, 1, 0, 1, acc, r, e); check("lhu_top_err", 32'(e), 32'd0);
        do_req(1, 0, F_LB,  32'h3FF, 0, 1, 0, 1, acc, r, e); check("lb_top_err", 32'(e), 32'd0);
        do_req(0, 1, F_LW,  32'h3FC, 32'h0BADBEEF, 1, 0, 1, acc, r, e);
        do_req(1, 0, F_LW,  32'h3FC, 0, 1, 0, 1, acc, r, e); check("lw_top", r, 32'h0BADBEEF);

        // Reset during RMW_MERGE of a halfword store abandons it
        do_req(0, 1, F_LH, 32'h102, 32'h0000BEEF, 0, 0, 0, acc, r, e);
        @(posedge clk); #1;
        rst = 1'b1;
        acc2 = wr_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("midrst_mem_wdata", mem_write_data, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_write", 32'(wr_cnt - acc2), 32'd0);
        check("midrst_word", mem[8'h40], 32'h889977BB);
        do_req(1, 0, F_LH, 32'h102, 0, 1, 0, 1, acc, r, e); check("lh_after_midrst", r, 32'hFFFF8899);

        for (int i = 0; i < 256; i++)
            check("mem_word", mem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, byte size of attached word memory (256 words).
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-003 SHALL have: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have: req_valid  input  1  pipeline access request.
REQ-005 SHALL have: req_ready  output  1  unit idle, request accepted this cycle.
REQ-006 SHALL have: req_load  input  1  load request (MemRead).
REQ-007 SHALL have: req_store  input  1  store request (MemWrite).
REQ-008 SHALL have: req_funct3  input  3  RV32I width/sign code.
REQ-009 SHALL have: req_addr  input  32  byte address.
REQ-010 SHALL have: req_wdata  input  32  store data, LSB-aligned.
REQ-011 SHALL have: resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have: resp_rdata  output  32  formatted load result, 0 for stores and errors.
REQ-013 SHALL have: resp_err  output  1  misaligned, out-of-range or illegal request.
REQ-014 SHALL have: mem_read, mem_write  output  1 each  to word memory.
REQ-015 SHALL have: mem_address  output  32  word-aligned address, bits [1:0] = 0.
REQ-016 SHALL have: mem_write_data  output  32  full word; mem_read_data  input  32  registered memory output.

Function
REQ-017 SHALL assert req_ready only in state IDLE; a request is accepted when req_valid and req_ready are both high; requests while busy are ignored.
REQ-018 SHALL latch load/store, funct3, addr and wdata on acceptance; pipeline inputs are don't-care afterwards.
REQ-019 SHALL treat as error: load and store both or neither high; funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores; halfword with addr[0]=1; word with addr[1:0]!=0; addr >= MEM_BYTES.
REQ-020 SHALL, on error, issue no memory access and pulse resp_valid with resp_err=1, resp_rdata=0 in the cycle after acceptance.
REQ-021 SHALL use states IDLE, LD_REQ, LD_CAP, ST_WR, RMW_RD, RMW_MERGE, RMW_WR, RESP.
REQ-022 Load (accept at T): LD_REQ at T+1 drives mem_read=1; LD_CAP at T+2 captures mem_read_data; RESP at T+3; latency 3.
REQ-023 Load formatting SHALL select byte lane addr[1:0] or halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-024 Word store: ST_WR at T+1 drives mem_write=1 with req_wdata; RESP at T+2; latency 2.
REQ-025 Byte/half store SHALL read-modify-write: RMW_RD at T+1 (mem_read), RMW_MERGE at T+2 replaces the addressed lane(s) of mem_read_data with wdata[7:0]/[15:0], RMW_WR at T+3 (mem_write), RESP at T+4; latency 4.
REQ-026 mem_read and mem_write SHALL never be high together and SHALL be 0 outside LD_REQ, RMW_RD, ST_WR, RMW_WR.
REQ-027 resp_valid SHALL be high exactly one cycle (RESP or error response), then IDLE; a new request may be accepted the cycle after.
REQ-028 resp_rdata and resp_err SHALL hold their values until the next response.

Reset
REQ-029 rst SHALL force IDLE, req_ready=1 in the next cycle, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
REQ-030 Reset mid-operation SHALL abandon the access with no response; an RMW interrupted before RMW_WR SHALL leave memory unmodified.

Structure
REQ-031 Package lsu_pkg SHALL hold funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enumeration.
REQ-032 Combinational sub-module lsu_align SHALL perform load lane extraction/extension and store lane merge.

Verification
REQ-033 Memory word 0x100 = 0x8899AABB; LB addr 0x102 -> resp at T+3, rdata 0xFFFFFF99; LBU same -> 0x00000099.
REQ-034 LH addr 0x102 on same word -> 0xFFFF8899; LHU -> 0x00008899; LW addr 0x100 -> 0x8899AABB.
REQ-035 SB 0x101 wdata 0x12345677 on 0x8899AABB -> memory 0x8899 77BB i.e. 0x889977BB, resp at T+4, single mem_write pulse.
REQ-036 LW addr 0x102 or SH addr 0x103 or addr 0x400 -> resp_err=1 at T+1, no mem_read/mem_write pulses.
REQ-037 Back-to-back SW then LW same address, req_valid held high while busy -> second accepted only after first resp_valid, load returns stored word.
REQ-038 rst asserted during RMW_MERGE of SH -> no mem_write, target word unchanged, req_ready=1 one cycle after rst.
